// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared state encoding, mode values and flag bit positions for the ALU sequencer
package alu_seq_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } state_t;
  localparam logic MODE_ARITH = 1'b0;
  localparam logic MODE_LOGIC = 1'b1;
  localparam int FLG_ZA = 4;
  localparam int FLG_ZB = 3;
  localparam int FLG_EQ = 2;
  localparam int FLG_GT = 1;
  localparam int FLG_LT = 0;
endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: command FIFO with wrap-bit pointers and a combinational head output
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 40
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wptr, rptr;
  assign empty = wptr == rptr;
  assign full = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign dout = mem[rptr[AW-1:0]];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) wptr <= wptr + ONE;
      if (pop && !empty) rptr <= rptr + ONE;
    end
  always_ff @(posedge clk)
    if (push && !full) mem[wptr[AW-1:0]] <= din;
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: queues ALU commands, drives registered ALU inputs, captures results after a settle time
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int SETTLE_CYCLES = 1,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [15:0]      cmd_a,
  input  logic [15:0]      cmd_b,
  input  logic [2:0]       cmd_opcode,
  input  logic             cmd_mode,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [15:0]      alu_a,
  output logic [15:0]      alu_b,
  output logic [2:0]       alu_opcode,
  output logic             alu_mode,
  input  logic [31:0]      alu_out,
  input  logic             alu_za,
  input  logic             alu_zb,
  input  logic             alu_eq,
  input  logic             alu_gt,
  input  logic             alu_lt,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic [4:0]       rsp_flags,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy,
  output logic [15:0]      op_count
);
  localparam int W = 36 + TAG_W;
  localparam int CW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
  state_t state, state_n;
  logic full, empty, push, pop, cap, hs;
  logic [W-1:0] head;
  logic [CW-1:0] cnt;
  logic [TAG_W-1:0] tag_r;
  assign cmd_ready = !full;
  assign push = cmd_valid && cmd_ready;
  assign pop = state == ST_IDLE && !empty;
  assign cap = state == ST_SETTLE && cnt == '0;
  assign hs = rsp_valid && rsp_ready;
  assign busy = state != ST_IDLE || !empty;
  alu_cmd_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .din({cmd_tag, cmd_mode, cmd_opcode, cmd_b, cmd_a}),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  always_comb begin
    state_n = state;
    state_n = pop ? ST_SETTLE : cap ? ST_RESP : hs ? ST_IDLE : state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= ST_IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {tag_r, alu_mode, alu_opcode, alu_b, alu_a} <= '0;
      cnt <= '0;
      rsp_valid <= 1'b0;
      rsp_result <= '0;
      rsp_flags <= '0;
      rsp_tag <= '0;
      op_count <= '0;
    end else begin
      if (pop) begin
        {tag_r, alu_mode, alu_opcode, alu_b, alu_a} <= head;
        cnt <= CW'(SETTLE_CYCLES - 1);
      end else if (state == ST_SETTLE && !cap) cnt <= cnt - CW'(1);
      if (cap) begin
        rsp_valid <= 1'b1;
        rsp_result <= alu_out;
        rsp_flags[FLG_ZA] <= alu_za;
        rsp_flags[FLG_ZB] <= alu_zb;
        rsp_flags[FLG_EQ] <= alu_eq;
        rsp_flags[FLG_GT] <= alu_gt;
        rsp_flags[FLG_LT] <= alu_lt;
        rsp_tag <= tag_r;
      end else if (hs) begin
        rsp_valid <= 1'b0;
        op_count <= op_count + 16'd1;
      end
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: randomized self-checking bench with an ALU stub and a queue-based reference model
module tb_alu_op_sequencer;
  logic clk, rst, cmd_valid, cmd_ready, cmd_mode, alu_mode, rsp_valid, rsp_ready, busy;
  logic [15:0] cmd_a, cmd_b, alu_a, alu_b, op_count;
  logic [2:0] cmd_opcode, alu_opcode;
  logic [3:0] cmd_tag, rsp_tag;
  logic [31:0] alu_out, rsp_result;
  logic [4:0] rsp_flags;
  logic alu_za, alu_zb, alu_eq, alu_gt, alu_lt;

  typedef struct {
    logic [31:0] r;
    logic [4:0] f;
    logic [3:0] t;
  } exp_t;
  exp_t q[$];
  int tests = 0, fails = 0;
  logic [15:0] cnt_model = 0;

  alu_op_sequencer #(.DEPTH(4), .SETTLE_CYCLES(1), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_opcode(cmd_opcode), .cmd_mode(cmd_mode), .cmd_tag(cmd_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_mode(alu_mode),
    .alu_out(alu_out), .alu_za(alu_za), .alu_zb(alu_zb), .alu_eq(alu_eq), .alu_gt(alu_gt), .alu_lt(alu_lt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .rsp_tag(rsp_tag), .busy(busy), .op_count(op_count)
  );

  assign alu_out = {alu_a, alu_b};
  assign alu_za = alu_a == 16'd0;
  assign alu_zb = alu_b == 16'd0;
  assign alu_eq = alu_a == alu_b;
  assign alu_gt = alu_a > alu_b;
  assign alu_lt = alu_a < alu_b;

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic [3:0] t);
    exp_t e;
    e.r = a * 32'h10000 + b;
    e.f = {a == 0, b == 0, a == b, a > b, a < b};
    e.t = t;
    return e;
  endfunction

  // All tasks start and end 1 time unit after a rising edge.
  task automatic push(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                      input logic m, input logic [3:0] t, output bit ok);
    cmd_a = a; cmd_b = b; cmd_opcode = op; cmd_mode = m; cmd_tag = t; cmd_valid = 1; ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (cmd_ready) begin
        ok = 1;
        q.push_back(model(a, b, t));
      end
      @(posedge clk); #1;
    end
    cmd_valid = 0;
  endtask

  task automatic recv(input bit rnd, output logic [31:0] r, output logic [4:0] f,
                      output logic [3:0] t, output bit ok);
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      rsp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rsp_valid && rsp_ready) begin
        r = rsp_result; f = rsp_flags; t = rsp_tag; ok = 1;
        cnt_model++;
      end
      @(posedge clk); #1;
    end
    rsp_ready = 0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = rsp_valid;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(posedge clk); #1;
      ok = rsp_valid;
    end
  endtask

  task automatic test_reset;
    bit ok;
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
    tests++; if ({rsp_valid, busy, op_count, alu_a, alu_b, alu_opcode, alu_mode, rsp_result, rsp_flags, rsp_tag} !== 95'd0) begin
      fails++; $display("FAIL reset_outputs: rsp_valid=%b busy=%b op_count=%h alu_a=%h rsp_result=%h want all 0", rsp_valid, busy, op_count, alu_a, rsp_result);
    end
    rst = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) push(16'h0100 + 16'(i), 16'h0200, 3'd1, 1'b0, 4'(i + 8), ok);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL midop_busy: got %b want 1", busy); end
    rst = 1; #1;
    tests++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL midreset_ready_busy: got %b/%b want 1/0", cmd_ready, busy); end
    tests++; if ({rsp_valid, op_count, alu_a, alu_b, alu_opcode, alu_mode, rsp_result, rsp_flags, rsp_tag} !== 94'd0) begin
      fails++; $display("FAIL midreset_outputs: rsp_valid=%b alu_a=%h rsp_tag=%h want all 0", rsp_valid, alu_a, rsp_tag);
    end
    @(posedge clk); #1;
    rst = 0;
    q.delete();
    cnt_model = 0;
    rsp_ready = 1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      tests++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL stale_after_reset: rsp_valid=%b busy=%b want 0/0", rsp_valid, busy); end
    end
    rsp_ready = 0;
  endtask

  task automatic test_single;
    bit ok;
    push(16'h0003, 16'h0004, 3'b000, 1'b0, 4'h5, ok);
    tests++; if (!ok) begin fails++; $display("FAIL single_push: timeout got 0 want 1"); end
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL single_lat_e: got %b want 0", rsp_valid); end
    @(posedge clk); #1;
    tests++; if (rsp_valid !== 1'b0 || alu_a !== 16'h0003 || alu_b !== 16'h0004) begin
      fails++; $display("FAIL single_pop: rsp_valid=%b alu_a=%h alu_b=%h want 0/0003/0004", rsp_valid, alu_a, alu_b);
    end
    @(posedge clk); #1;
    tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL single_lat_e2: got %b want 1", rsp_valid); end
    tests++; if (rsp_result !== 32'h00030004 || rsp_flags !== 5'b00001 || rsp_tag !== 4'h5) begin
      fails++; $display("FAIL single_rsp: got %h/%b/%h want 00030004/00001/5", rsp_result, rsp_flags, rsp_tag);
    end
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
    cnt_model++;
    void'(q.pop_front());
    tests++; if (op_count !== 16'd1 || rsp_valid !== 1'b0) begin fails++; $display("FAIL single_count: op_count=%h rsp_valid=%b want 1/0", op_count, rsp_valid); end
  endtask

  task automatic test_flags;
    bit ok;
    logic [31:0] r; logic [4:0] f; logic [3:0] t;
    push(16'h0000, 16'h0000, 3'd2, 1'b0, 4'h1, ok);
    recv(0, r, f, t, ok);
    void'(q.pop_front());
    tests++; if (!ok || f !== 5'b11100) begin fails++; $display("FAIL flags_zero: got %b want 11100", f); end
    push(16'h0009, 16'h0002, 3'd3, 1'b1, 4'h2, ok);
    @(posedge clk); #1;
    tests++; if (alu_mode !== 1'b1 || alu_opcode !== 3'd3) begin fails++; $display("FAIL flags_mode: got %b/%d want 1/3", alu_mode, alu_opcode); end
    recv(0, r, f, t, ok);
    void'(q.pop_front());
    tests++; if (!ok || f !== 5'b00010 || r !== 32'h00090002 || t !== 4'h2) begin
      fails++; $display("FAIL flags_gt: got %b/%h/%h want 00010/00090002/2", f, r, t);
    end
  endtask

  task automatic test_full;
    bit ok;
    logic [31:0] r; logic [4:0] f; logic [3:0] t;
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      push(16'h1000 + 16'(i), 16'h0100 * 16'(i), 3'(i), 1'(i), 4'(i), ok);
      tests++; if (!ok) begin fails++; $display("FAIL full_push%0d: timeout got 0 want 1", i); end
    end
    tests++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL full_ready: got %b want 0", cmd_ready); end
    for (int i = 0; i < 5; i++) begin
      recv(0, r, f, t, ok);
      e = q.pop_front();
      tests++; if (!ok || t !== 4'(i) || r !== e.r || f !== e.f) begin
        fails++; $display("FAIL full_order%0d: got %h/%h/%b want %h/%h/%b", i, t, r, f, 4'(i), e.r, e.f);
      end
    end
  endtask

  task automatic test_backpressure;
    bit ok;
    logic [31:0] r; logic [4:0] f; logic [3:0] t;
    exp_t e;
    push(16'h1111, 16'h2222, 3'd4, 1'b0, 4'hA, ok);
    push(16'h2222, 16'h1111, 3'd5, 1'b1, 4'hB, ok);
    wait_valid(ok);
    tests++; if (!ok) begin fails++; $display("FAIL bp_valid: timeout got 0 want 1"); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      tests++; if (rsp_valid !== 1'b1 || rsp_result !== q[0].r || rsp_tag !== 4'hA || alu_a !== 16'h1111) begin
        fails++; $display("FAIL bp_hold: valid=%b result=%h tag=%h alu_a=%h want 1/%h/a/1111", rsp_valid, rsp_result, rsp_tag, alu_a, q[0].r);
      end
    end
    for (int i = 0; i < 2; i++) begin
      recv(0, r, f, t, ok);
      e = q.pop_front();
      tests++; if (!ok || r !== e.r || f !== e.f || t !== e.t) begin
        fails++; $display("FAIL bp_drain%0d: got %h/%b/%h want %h/%b/%h", i, r, f, t, e.r, e.f, e.t);
      end
    end
  endtask

  task automatic test_random;
    localparam int N = 40;
    fork
      begin
        bit ok;
        for (int i = 0; i < N; i++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          push(16'($urandom_range(0, 3) == 0 ? 0 : $urandom), 16'($urandom_range(0, 3) == 0 ? 0 : $urandom),
               3'($urandom), 1'($urandom), 4'($urandom), ok);
          tests++; if (!ok) begin fails++; $display("FAIL rnd_push%0d: timeout got 0 want 1", i); end
        end
      end
      begin
        bit ok;
        logic [31:0] r; logic [4:0] f; logic [3:0] t;
        exp_t e;
        for (int j = 0; j < N; j++) begin
          recv(1, r, f, t, ok);
          tests++;
          if (!ok || q.size() == 0) begin
            fails++; $display("FAIL rnd_rsp%0d: ok=%b queued=%0d want 1/>0", j, ok, q.size());
          end else begin
            e = q.pop_front();
            if (r !== e.r || f !== e.f || t !== e.t) begin
              fails++; $display("FAIL rnd_rsp%0d: got %h/%b/%h want %h/%b/%h", j, r, f, t, e.r, e.f, e.t);
            end
          end
        end
      end
    join
    tests++; if (op_count !== cnt_model) begin fails++; $display("FAIL rnd_count: got %h want %h", op_count, cnt_model); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rnd_idle: busy got %b want 0", busy); end
  endtask

  task automatic test_wrap;
    bit ok;
    logic [31:0] r; logic [4:0] f; logic [3:0] t;
    force dut.op_count = 16'hFFFE;
    @(posedge clk); #1;
    release dut.op_count;
    cnt_model = 16'hFFFE;
    tests++; if (op_count !== 16'hFFFE) begin fails++; $display("FAIL wrap_preload: got %h want fffe", op_count); end
    push(16'h0007, 16'h0007, 3'd0, 1'b0, 4'h3, ok);
    recv(0, r, f, t, ok);
    void'(q.pop_front());
    tests++; if (op_count !== 16'hFFFF || op_count !== cnt_model) begin fails++; $display("FAIL wrap_ffff: got %h want ffff", op_count); end
    tests++; if (f !== 5'b00100) begin fails++; $display("FAIL wrap_eq_flags: got %b want 00100", f); end
    push(16'h0001, 16'h0002, 3'd0, 1'b0, 4'h4, ok);
    recv(0, r, f, t, ok);
    void'(q.pop_front());
    tests++; if (op_count !== 16'h0000 || op_count !== cnt_model) begin fails++; $display("FAIL wrap_zero: got %h want 0000", op_count); end
  endtask

  initial begin
    rst = 1; cmd_valid = 0; rsp_ready = 0;
    cmd_a = 0; cmd_b = 0; cmd_opcode = 0; cmd_mode = 0; cmd_tag = 0;
    #1;
    test_reset;
    test_single;
    test_flags;
    test_full;
    test_backpressure;
    test_random;
    test_wrap;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
